// File: rtl/line_fetch_fsm_pkg.sv
// Shared types and helpers for the line fetch sequencer: state encoding,
// derived-width helper and an unsigned min used for burst sizing.
package line_fetch_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_CHECK      = 3'd2,
        ST_REQ        = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_ADVANCE    = 3'd5
    } state_e;

    // Width of a field that must hold the value n itself (0..n).
    function automatic int count_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int LEN_W = count_w(16);
    localparam int LVL_W = count_w(128);

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/line_fetch_fsm_addr_calc.sv
// Frame geometry shadows plus the line/word position counters; derives the
// current burst length and byte address combinationally.
module fetch_addr_calc
    import line_fetch_fsm_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int BURST_WORDS    = 16,
    parameter int BYTES_PER_WORD = 4,
    parameter int LPW_W          = 16,
    parameter int LINES_W        = 12,
    parameter int LEN_W_P        = count_w(BURST_WORDS)
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                load_i,
    input  logic                advance_i,
    input  logic [ADDR_W-1:0]   base_i,
    input  logic [ADDR_W-1:0]   stride_i,
    input  logic [LPW_W-1:0]    wpl_i,
    input  logic [LINES_W-1:0]  lines_i,
    output logic [LEN_W_P-1:0]  len_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                frame_last_o
);

    logic [ADDR_W-1:0]  stride_q;
    logic [LPW_W-1:0]   wpl_q;
    logic [LINES_W-1:0] lines_q;
    logic [ADDR_W-1:0]  line_addr_q;
    logic [LPW_W-1:0]   word_off_q;
    logic [LINES_W-1:0] line_cnt_q;

    logic [LPW_W-1:0]   remaining;
    logic [LPW_W-1:0]   word_off_sum;
    logic [LINES_W:0]   line_cnt_inc;
    logic               line_end;

    always_comb begin
        remaining    = wpl_q - word_off_q;
        len_o        = LEN_W_P'(min_u32(32'(remaining), 32'(BURST_WORDS)));
        addr_o       = line_addr_q + (ADDR_W'(word_off_q) * ADDR_W'(BYTES_PER_WORD));
        word_off_sum = word_off_q + LPW_W'(len_o);
        line_end     = (word_off_sum == wpl_q);
        // Counted one bit wider so a full 2^LINES_W-1 frame cannot alias to 0.
        line_cnt_inc = (LINES_W+1)'(line_cnt_q) + (LINES_W+1)'(1);
        frame_last_o = line_end && (line_cnt_inc == (LINES_W+1)'(lines_q));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            stride_q    <= '0;
            wpl_q       <= '0;
            lines_q     <= '0;
            line_addr_q <= '0;
            word_off_q  <= '0;
            line_cnt_q  <= '0;
        end else if (load_i) begin
            stride_q    <= stride_i;
            wpl_q       <= wpl_i;
            lines_q     <= lines_i;
            line_addr_q <= base_i;
            word_off_q  <= '0;
            line_cnt_q  <= '0;
        end else if (advance_i) begin
            if (line_end) begin
                word_off_q  <= '0;
                line_addr_q <= line_addr_q + stride_q;
                line_cnt_q  <= line_cnt_q + LINES_W'(1);
            end else begin
                word_off_q  <= word_off_sum;
            end
        end
    end

endmodule

// File: rtl/line_fetch_fsm.sv
// Burst read sequencer filling the pixel FIFO line by line; one burst in
// flight at a time, throttled by FIFO free space, frame-sync slips tracked.
module line_fetch_fsm
    import line_fetch_fsm_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int BURST_WORDS    = 16,
    parameter int FIFO_DEPTH     = 128,
    parameter int BYTES_PER_WORD = 4,
    parameter int LPW_W          = 16,
    parameter int LINES_W        = 12,
    parameter int LEN_W_P        = count_w(BURST_WORDS),
    parameter int LVL_W_P        = count_w(FIFO_DEPTH)
) (
    input  logic                Bus2IP_Clk,
    input  logic                Bus2IP_Reset,
    input  logic                enable,
    input  logic                frame_start,
    input  logic [ADDR_W-1:0]   frame_base_addr,
    input  logic [ADDR_W-1:0]   line_stride,
    input  logic [LPW_W-1:0]    words_per_line,
    input  logic [LINES_W-1:0]  num_lines,
    input  logic [LVL_W_P-1:0]  fifo_level,
    output logic                fetch_req,
    output logic [ADDR_W-1:0]   fetch_addr,
    output logic [LEN_W_P-1:0]  fetch_len,
    input  logic                fetch_ack,
    input  logic                fetch_done,
    output logic                frame_done,
    output logic                busy,
    output logic                sync_err
);

    state_e              state_q, state_d;
    logic                fetch_req_q, fetch_req_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [LEN_W_P-1:0]  fetch_len_q, fetch_len_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic                sync_err_q, sync_err_d;
    logic                pend_q, pend_d;

    logic                load;
    logic                advance;
    logic [LEN_W_P-1:0]  calc_len;
    logic [ADDR_W-1:0]   calc_addr;
    logic                frame_last;
    logic                has_space;
    logic                geom_empty;
    state_e              restart_state;

    fetch_addr_calc #(
        .ADDR_W         (ADDR_W),
        .BURST_WORDS    (BURST_WORDS),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .LPW_W          (LPW_W),
        .LINES_W        (LINES_W),
        .LEN_W_P        (LEN_W_P)
    ) u_addr_calc (
        .clk          (Bus2IP_Clk),
        .srst         (Bus2IP_Reset),
        .load_i       (load),
        .advance_i    (advance),
        .base_i       (frame_base_addr),
        .stride_i     (line_stride),
        .wpl_i        (words_per_line),
        .lines_i      (num_lines),
        .len_o        (calc_len),
        .addr_o       (calc_addr),
        .frame_last_o (frame_last)
    );

    // Geometry being latched this cycle is the live input, so the empty-frame
    // test looks at the inputs rather than the shadows.
    assign geom_empty    = (words_per_line == '0) || (num_lines == '0);
    assign restart_state = geom_empty ? ST_WAIT_FRAME : ST_CHECK;
    assign has_space     = (32'(fifo_level) + 32'(calc_len)) <= 32'(FIFO_DEPTH);

    always_comb begin
        state_d      = state_q;
        fetch_req_d  = fetch_req_q;
        fetch_addr_d = fetch_addr_q;
        fetch_len_d  = fetch_len_q;
        frame_done_d = 1'b0;
        sync_err_d   = sync_err_q;
        pend_d       = pend_q;
        load         = 1'b0;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    load    = 1'b1;
                    state_d = restart_state;
                end
            end
            ST_CHECK: begin
                if (frame_start) sync_err_d = 1'b1;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    load    = 1'b1;
                    state_d = restart_state;
                end else if (has_space) begin
                    state_d      = ST_REQ;
                    fetch_req_d  = 1'b1;
                    fetch_addr_d = calc_addr;
                    fetch_len_d  = calc_len;
                end
            end
            ST_REQ: begin
                if (frame_start) sync_err_d = 1'b1;
                // An ack always wins; a coincident frame_start waits for the burst.
                if (fetch_ack) begin
                    fetch_req_d = 1'b0;
                    state_d     = ST_WAIT_DONE;
                    if (frame_start) pend_d = 1'b1;
                end else if (!enable) begin
                    fetch_req_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (frame_start) begin
                    fetch_req_d = 1'b0;
                    load        = 1'b1;
                    state_d     = restart_state;
                end
            end
            ST_WAIT_DONE: begin
                if (frame_start) sync_err_d = 1'b1;
                if (fetch_done) begin
                    if (pend_q || frame_start) begin
                        pend_d  = 1'b0;
                        load    = 1'b1;
                        state_d = restart_state;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end else if (frame_start) begin
                    pend_d = 1'b1;
                end
            end
            ST_ADVANCE: begin
                if (frame_start) begin
                    sync_err_d = 1'b1;
                    load       = 1'b1;
                    state_d    = restart_state;
                end else begin
                    advance = 1'b1;
                    if (frame_last) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_WAIT_FRAME;
                    end else if (!enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                fetch_req_d = 1'b0;
            end
        endcase

        if (load && geom_empty) frame_done_d = 1'b1;
        if (state_d == ST_IDLE) pend_d = 1'b0;
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_WAIT_FRAME));
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q      <= ST_IDLE;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= '0;
            fetch_len_q  <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            sync_err_q   <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_len_q  <= fetch_len_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            sync_err_q   <= sync_err_d;
            pend_q       <= pend_d;
        end
    end

    assign fetch_req  = fetch_req_q;
    assign fetch_addr = fetch_addr_q;
    assign fetch_len  = fetch_len_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign sync_err   = sync_err_q;

endmodule

// File: doc/line_fetch_fsm.md
Name: line_fetch_fsm

Overview:
Parametrised successor to the HDMI-out FIFO fill sequencer. It generates burst read requests (address and length) from DDR into the pixel FIFO, line by line and frame by frame. Requests are throttled by actual FIFO free space rather than a fixed half-fill point. Frame geometry is shadowed at frame start, and frame-sync slips are handled explicitly. The block sits between the software slave registers / display timing core and the bus-master read engine in user_logic.

Parameters:
ADDR_W, 32, byte address width
BURST_WORDS, 16, maximum words per burst request
FIFO_DEPTH, 128, pixel FIFO depth in words
BYTES_PER_WORD, 4, bytes per FIFO word (address increment per word)
LPW_W, 16, width of words-per-line field
LINES_W, 12, width of line-count field

Ports:
Bus2IP_Clk  in  1  system clock
Bus2IP_Reset  in  1  synchronous active-high reset
enable  in  1  software run bit
frame_start  in  1  one-cycle pulse from display timing (start of vsync)
frame_base_addr  in  ADDR_W  byte address of line 0
line_stride  in  ADDR_W  byte distance between line starts
words_per_line  in  LPW_W  words fetched per line
num_lines  in  LINES_W  lines per frame
fifo_level  in  clog2(FIFO_DEPTH)+1  current FIFO occupancy in words
fetch_req  out  1  burst request valid
fetch_addr  out  ADDR_W  burst start byte address
fetch_len  out  clog2(BURST_WORDS)+1  burst length in words
fetch_ack  in  1  master accepted request (same-cycle handshake with fetch_req)
fetch_done  in  1  one-cycle pulse: last word of current burst written to FIFO
frame_done  out  1  one-cycle pulse after last burst of a frame completes
busy  out  1  high in any state other than IDLE / WAIT_FRAME
sync_err  out  1  sticky; frame_start arrived while a frame was incomplete

Behaviour:
- Reset values: all outputs 0; state IDLE; all internal counters and shadow registers 0.
- States: IDLE, WAIT_FRAME, CHECK, REQ, WAIT_DONE, ADVANCE.
- IDLE -> WAIT_FRAME when enable=1.
- WAIT_FRAME, on frame_start:
  - latch base, stride, words_per_line and num_lines into shadow registers;
  - line_addr <= base; word_off <= 0; line_cnt <= 0.
  - If shadow words_per_line==0 or num_lines==0: pulse frame_done next cycle, stay in WAIT_FRAME, issue no requests.
  - Otherwise go to CHECK.
- CHECK:
  - len = min(BURST_WORDS, wpl - word_off).
  - Go to REQ when FIFO_DEPTH - fifo_level >= len; otherwise stay.
- REQ:
  - fetch_req=1; fetch_addr = line_addr + word_off*BYTES_PER_WORD; fetch_len = len.
  - All three outputs are registered and held stable until the cycle with fetch_ack=1; fetch_req drops the next cycle.
  - Go to WAIT_DONE on ack.
- WAIT_DONE -> ADVANCE on fetch_done. A fetch_done seen outside WAIT_DONE is ignored.
- ADVANCE (single cycle): word_off += len.
  - If word_off == wpl: word_off <= 0; line_addr += stride; line_cnt += 1.
  - If line_cnt then equals num_lines: pulse frame_done, go to WAIT_FRAME.
  - Else if enable=0: go to IDLE.
  - Else: go to CHECK.
- Only one burst is outstanding at any time. Minimum request-to-request spacing is ack, done, ADVANCE, CHECK: 3 cycles plus master latency.
- Arithmetic: address sums are modulo 2^ADDR_W (wrap silently). word_off*BYTES_PER_WORD is computed at ADDR_W width.
- frame_start while in CHECK, REQ, WAIT_DONE or ADVANCE:
  - set sync_err;
  - from CHECK, or from REQ before ack: abandon the frame, relatch the shadows, restart at line 0;
  - from WAIT_DONE or ADVANCE: remember it pending, wait for fetch_done, then relatch and restart (a burst is never orphaned).
  - A frame_start coincident with fetch_ack: the ack wins (go to WAIT_DONE), and the start is held pending.
- enable deassert: no new request is issued. An in-flight burst (acked) completes; REQ before ack is withdrawn. Then go to IDLE. sync_err is cleared only by reset.
- Reset mid-burst: immediate return to IDLE. The master must be reset by the same signal.

Decomposition:
- Shared package: state encodings, LEN_W/LVL_W derived-width constants, min-of-two helper function.
- One natural sub-module, fetch_addr_calc: holds line_addr, word_off, line_cnt and computes len/fetch_addr combinationally. The FSM drives its load, advance and restart strobes.

Test Plan:
- Single frame, base=0x1000_0000, stride=0x1000, wpl=40, lines=2, fifo_level=0, ack/done immediate.
  - Required bursts (addr/len): 0x10000000/16, 0x10000040/16, 0x10000080/8, 0x10001000/16, 0x10001040/16, 0x10001080/8.
  - frame_done pulses once after the 6th done.
- Throttle: fifo_level=120 with FIFO_DEPTH=128, BURST=16.
  - No fetch_req while the level stays at 120.
  - Drop the level to 112: fetch_req asserts within 2 cycles.
- Handshake hold: delay fetch_ack 5 cycles.
  - fetch_req, fetch_addr and fetch_len remain constant throughout.
  - fetch_req deasserts the cycle after ack.
- Sync slip: frame_start during WAIT_DONE of line 1.
  - sync_err=1.
  - The next request is issued only after fetch_done and starts at the new base, line 0.
- Degenerate/wrap: wpl=0 -> frame_done with zero requests.
  - base=0xFFFF_FFC0, wpl=32 -> second burst addr 0x0000_0000.
- enable drop while REQ unacked -> fetch_req withdraws, busy=0 within 2 cycles, no further requests.
